// File: rtl/multi_core_sleep_unit.sv
// APB-programmed sleep controller: one RUN/SHUTDOWN/SLEEP machine per core,
// driving fetch enables and clock gates from per-core wake masks and IRQs.
module multi_core_sleep_unit #(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int NB_CORES       = 4,
    parameter int NB_EVENTS      = 8,
    parameter int TIMEOUT_WIDTH  = 16
) (
    input  logic                      HCLK,
    input  logic                      HRESETn,
    input  logic [APB_ADDR_WIDTH-1:0] PADDR,
    input  logic [31:0]               PWDATA,
    input  logic                      PWRITE,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    output logic [31:0]               PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    input  logic [NB_CORES-1:0]       irq_i,
    input  logic [NB_EVENTS-1:0]      event_i,
    input  logic [NB_CORES-1:0]       core_busy_i,
    output logic [NB_CORES-1:0]       fetch_en_o,
    output logic [NB_CORES-1:0]       clk_gate_core_o
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SHUTDOWN = 2'd1,
        SLEEP    = 2'd2
    } state_e;

    logic [7:0] word_idx;
    logic [3:0] core_idx;
    logic       access, wr_access;
    logic       core_hit, ctrl_hit, mask_hit, status_hit, timeout_hit, mapped;

    logic [TIMEOUT_WIDTH-1:0] timeout_reg;
    logic [NB_CORES-1:0]      sleep_en_vec, abort_vec, status_vec;
    logic [NB_EVENTS-1:0]     mask_arr [NB_CORES];

    // Each core owns a 16-byte window: CTRL, WAKE_MASK, then two unmapped words.
    assign word_idx    = PADDR[9:2];
    assign core_idx    = word_idx[5:2];
    assign access      = PSEL & PENABLE;
    assign wr_access   = access & PWRITE;
    assign core_hit    = (word_idx[7:6] == 2'b00) && ({1'b0, core_idx} < 5'(NB_CORES));
    assign ctrl_hit    = core_hit && (word_idx[1:0] == 2'd0);
    assign mask_hit    = core_hit && (word_idx[1:0] == 2'd1);
    assign status_hit  = (word_idx == 8'h40);
    assign timeout_hit = (word_idx == 8'h41);
    assign mapped      = ctrl_hit | mask_hit | status_hit | timeout_hit;

    assign PREADY  = 1'b1;
    assign PSLVERR = access & (~mapped | (PWRITE & status_hit));

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            timeout_reg <= '0;
        end else if (wr_access && timeout_hit) begin
            timeout_reg <= PWDATA[TIMEOUT_WIDTH-1:0];
        end
    end

    always_comb begin
        PRDATA = '0;
        if (access && !PWRITE) begin
            if (status_hit) begin
                PRDATA = 32'(status_vec);
            end else if (timeout_hit) begin
                PRDATA = 32'(timeout_reg);
            end else begin
                for (int c = 0; c < NB_CORES; c++) begin
                    if (core_idx == 4'(c)) begin
                        if (ctrl_hit)
                            PRDATA = {30'b0, abort_vec[c], sleep_en_vec[c]};
                        else if (mask_hit)
                            PRDATA = 32'(mask_arr[c]);
                    end
                end
            end
        end
    end

    for (genvar gi = 0; gi < NB_CORES; gi++) begin : g_core
        state_e                   state_reg, state_next;
        logic [TIMEOUT_WIDTH-1:0] cnt_reg, cnt_next;
        logic                     sleep_en_reg, abort_reg, status_reg;
        logic [NB_EVENTS-1:0]     wake_mask_reg;
        logic                     wake, wr_ctrl, wr_mask;
        logic                     hw_clr_sleep, hw_set_abort, fetch, gate;

        assign wake    = irq_i[gi] | (|(event_i & wake_mask_reg));
        assign wr_ctrl = wr_access & ctrl_hit & (core_idx == 4'(gi));
        assign wr_mask = wr_access & mask_hit & (core_idx == 4'(gi));

        always_ff @(posedge HCLK or negedge HRESETn) begin
            if (!HRESETn) begin
                state_reg <= RUN;
                cnt_reg   <= '0;
            end else begin
                state_reg <= state_next;
                cnt_reg   <= cnt_next;
            end
        end

        // Priority inside SHUTDOWN: wake, then timeout abort, then core idle.
        always_comb begin
            state_next   = state_reg;
            cnt_next     = cnt_reg;
            hw_clr_sleep = 1'b0;
            hw_set_abort = 1'b0;
            fetch        = 1'b1;
            gate         = 1'b1;
            case (state_reg)
                RUN: begin
                    fetch = ~(sleep_en_reg & ~wake);
                    if (sleep_en_reg && !wake) begin
                        state_next = SHUTDOWN;
                        cnt_next   = '0;
                    end
                end
                SHUTDOWN: begin
                    fetch    = 1'b0;
                    cnt_next = (&cnt_reg) ? cnt_reg : cnt_reg + TIMEOUT_WIDTH'(1);
                    if (wake) begin
                        state_next   = RUN;
                        hw_clr_sleep = 1'b1;
                    end else if ((timeout_reg != '0) &&
                                 (cnt_reg == timeout_reg - TIMEOUT_WIDTH'(1))) begin
                        state_next   = RUN;
                        hw_clr_sleep = 1'b1;
                        hw_set_abort = 1'b1;
                    end else if (!core_busy_i[gi]) begin
                        state_next   = SLEEP;
                        hw_clr_sleep = 1'b1;
                    end
                end
                SLEEP: begin
                    fetch = 1'b0;
                    gate  = wake;
                    if (wake)
                        state_next = RUN;
                end
                default: state_next = RUN;
            endcase
        end

        // Software writes override hardware clears; a fresh abort beats W1C.
        always_ff @(posedge HCLK or negedge HRESETn) begin
            if (!HRESETn) begin
                sleep_en_reg  <= 1'b0;
                abort_reg     <= 1'b0;
                status_reg    <= 1'b0;
                wake_mask_reg <= '0;
            end else begin
                status_reg <= (state_reg == SLEEP);
                if (wr_ctrl)
                    sleep_en_reg <= PWDATA[0];
                else if (hw_clr_sleep)
                    sleep_en_reg <= 1'b0;
                if (hw_set_abort)
                    abort_reg <= 1'b1;
                else if (wr_ctrl && PWDATA[1])
                    abort_reg <= 1'b0;
                if (wr_mask)
                    wake_mask_reg <= PWDATA[NB_EVENTS-1:0];
            end
        end

        assign fetch_en_o[gi]      = fetch;
        assign clk_gate_core_o[gi] = gate;
        assign sleep_en_vec[gi]    = sleep_en_reg;
        assign abort_vec[gi]       = abort_reg;
        assign status_vec[gi]      = status_reg;
        assign mask_arr[gi]        = wake_mask_reg;
    end

endmodule
